// File: rtl/inst_fetch_ctrl.sv
// Instruction fetch sequencer: owns the PC and feeds decode through a one-entry valid/ready stage.
// Define FETCH_PERF_EN to add the saturating fetch_cnt/stall_cnt performance counters.
module inst_fetch_ctrl #(
    parameter int                 ADDR_W     = 64,
    parameter int                 INSTR_W    = 32,
    parameter logic [ADDR_W-1:0]  RESET_PC   = '0,
    parameter int                 MEM_BYTES  = 64,
    parameter logic [INSTR_W-1:0] HALT_INSTR = 32'h0010_0073
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               en,
    output logic [ADDR_W-1:0]  read_adr,
    input  logic [INSTR_W-1:0] instruction,
    input  logic               redirect_valid,
    input  logic [ADDR_W-1:0]  redirect_pc,
    output logic               if_valid,
    input  logic               if_ready,
    output logic [INSTR_W-1:0] if_instr,
    output logic [ADDR_W-1:0]  if_pc,
    output logic               halted,
    output logic               fault,
    output logic [2:0]         state
`ifdef FETCH_PERF_EN
    ,
    output logic [31:0]        fetch_cnt,
    output logic [31:0]        stall_cnt
`endif
);

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_FETCH = 3'd1,
        ST_STALL = 3'd2,
        ST_HALT  = 3'd3,
        ST_FAULT = 3'd4
    } state_t;

    localparam logic [ADDR_W-1:0] MEM_LIMIT = ADDR_W'(MEM_BYTES);

    state_t              cur_st;
    state_t              nxt_st;
    logic [ADDR_W-1:0]   pc_p0;
    logic [INSTR_W-1:0]  instr_p1;
    logic [ADDR_W-1:0]   ipc_p1;
    logic                vld_p1;
    logic                halted_q;
    logic                fault_q;

    logic                active;
    logic                slot_free;
    logic                pc_bad;
    logic                is_halt;
    logic                capture;

    assign active    = (cur_st == ST_FETCH) || (cur_st == ST_STALL);
    assign slot_free = !vld_p1 || if_ready;
    assign pc_bad    = (pc_p0[1:0] != 2'b00) || (pc_p0 >= MEM_LIMIT);
    assign is_halt   = (instruction == HALT_INSTR);
    // Redirect and fault check both pre-empt a capture in the same cycle.
    assign capture   = active && !redirect_valid && !pc_bad && slot_free;

    always_ff @(posedge clk) begin
        if (rst) cur_st <= ST_IDLE;
        else     cur_st <= nxt_st;
    end

    always_comb begin
        nxt_st = cur_st;
        case (cur_st)
            ST_IDLE: begin
                if (en) nxt_st = ST_FETCH;
            end
            ST_FETCH, ST_STALL: begin
                if (redirect_valid)  nxt_st = ST_FETCH;
                else if (pc_bad)     nxt_st = ST_FAULT;
                else if (slot_free)  nxt_st = is_halt ? ST_HALT : ST_FETCH;
                else                 nxt_st = ST_STALL;
            end
            ST_HALT, ST_FAULT: nxt_st = cur_st;
            default:           nxt_st = ST_IDLE;
        endcase
    end

    // Stage p0 -> p1: PC issue and output-stage capture
    always_ff @(posedge clk) begin
        if (rst) begin
            pc_p0    <= RESET_PC;
            instr_p1 <= '0;
            ipc_p1   <= '0;
            vld_p1   <= 1'b0;
            halted_q <= 1'b0;
            fault_q  <= 1'b0;
        end else if (active && redirect_valid) begin
            pc_p0  <= redirect_pc;
            vld_p1 <= 1'b0;
        end else if (active && pc_bad) begin
            vld_p1  <= 1'b0;
            fault_q <= 1'b1;
        end else if (capture) begin
            instr_p1 <= instruction;
            ipc_p1   <= pc_p0;
            vld_p1   <= 1'b1;
            if (is_halt) halted_q <= 1'b1;
            else         pc_p0    <= pc_p0 + ADDR_W'(4);
        end else if (vld_p1 && if_ready) begin
            vld_p1 <= 1'b0;
        end
    end

    assign read_adr = pc_p0;
    assign if_valid = vld_p1;
    assign if_instr = instr_p1;
    assign if_pc    = ipc_p1;
    assign halted   = halted_q;
    assign fault    = fault_q;
    assign state    = cur_st;

`ifdef FETCH_PERF_EN
    function automatic logic [31:0] sat_inc(input logic [31:0] v);
        return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
    endfunction

    always_ff @(posedge clk) begin
        if (rst) begin
            fetch_cnt <= '0;
            stall_cnt <= '0;
        end else begin
            if (capture)            fetch_cnt <= sat_inc(fetch_cnt);
            if (cur_st == ST_STALL) stall_cnt <= sat_inc(stall_cnt);
        end
    end
`endif

endmodule
